ky32_dmem_resp: RTL and testbench
=================================

Name: ky32_dmem_resp

Overview:
Data-memory responder for the KY32 RV32I core: the slave end of the core's load/store interface. It accepts one request at a time (address, store data, funct3 size code, write flag), waits a programmable number of cycles, then performs the access. Loads are returned lane-steered and sign- or zero-extended. Instances sit beside the core in the system top and can also serve as the bench memory model.

Parameters:
DEPTH, 1024, memory size in 32-bit words (power of two, 16..65536)
LATENCY, 1, wait cycles between request accept and response (0..15)
BASE, 32'h0000_0000, byte address of word 0

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size  in  3  RV32I funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  out  1  access faulted; no memory write occurred

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=0 while rst=1. Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
  - IDLE: req_ready=1.
    - If req_valid=1: latch we/addr/wdata/size and go to WAIT with cnt=LATENCY-1.
    - If LATENCY=0: go straight to RESP and perform the access in the same edge.
  - WAIT: req_ready=0. Decrement cnt. On the edge where cnt==0, perform the access and go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready. That edge returns to IDLE. No new request is accepted in the same cycle (one-request-outstanding, no bypass).
- Latency: the response is visible LATENCY+1 cycles after the accept edge. Throughput is at most one request per LATENCY+2 cycles.
- Addressing: off = addr - BASE (32-bit wrap); word index = off[31:2].
  - Out of range when off[31:2] >= DEPTH: rsp_err=1, no write.
- Size codes:
  - Invalid load codes: 011, 110, 111.
  - Invalid store codes: anything except 000, 001, 010.
  - An invalid code sets rsp_err=1.
- Stores:
  - Byte enable: SB = 1 lane at off[1:0]; SH = lanes {off[1],0} pair; SW = all lanes.
  - Only enabled lanes are written.
  - rsp_rdata=0.
- Loads:
  - Select the lane(s) by off[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
- Error priority: invalid size > out of range > misaligned (feature).
- Reset mid-operation: a request in WAIT is dropped and not written; a response in RESP is discarded.

Optional Feature:
KY32_DMEM_MISALIGN_TRAP_EN
- Defined: a halfword with off[0]=1 or a word with off[1:0]!=0 gives rsp_err=1, no write, rsp_rdata=0.
- Undefined: the offending low bits are forced to zero. The halfword aligns to off[1] and the word aligns down; the access completes with rsp_err=0.

Decomposition:
- Package ky32_mem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - FSM state encoding (2-bit)
  - lane/byte-enable width constant (4)
- Sub-module ky32_lsu_align (combinational):
  - from size and off[1:0], produces the byte enable, the store data replicated across lanes, and the extended load data
  - also reports invalid/misaligned flags
- The FSM, counter, array and response registers stay in ky32_dmem_resp.

Test Plan:
1. LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err 0.
2. SB 0x13 data 0x80 over 0x11223344 -> LW 0x10 = 0x80223344; LB 0x13 = 0xFFFFFF80; LBU 0x13 = 0x00000080; LH 0x12 = 0xFFFF8022.
3. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable; req_ready=0; a second req_valid is not accepted until the cycle after the response handshake.
4. Errors:
   - LW at BASE+4*DEPTH -> err=1, rdata 0.
   - Store with size 100 -> err=1, memory unchanged.
   - LW at 0x12 -> err=1 with the macro; without it, returns the word at 0x10 with err=0.
5. LATENCY=0 and LATENCY=15: the response comes 1 and 16 cycles after accept respectively.
6. Assert rst during WAIT of SW 0x20 data 0x5 -> next cycle rsp_valid=0 and req_ready=1 (after rst low); LW 0x20 returns the prior contents, not 0x5.

Source files
------------

// File: rtl/ky32_mem_pkg.sv
// ============================================================================
// Module   : ky32_mem_pkg
// Purpose  : Shared funct3 codes, lane width and FSM encoding for KY32 dmem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ky32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ky32_lsu_align.sv
// ============================================================================
// Module   : ky32_lsu_align
// Purpose  : Byte-lane steering for loads/stores; flags bad sizes/alignment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ky32_lsu_align
  import ky32_mem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      size,
  input  logic [1:0]      off_lo,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rword,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_rep,
  output logic [31:0]     rdata_ext,
  output logic            invalid,
  output logic            misaligned
);

  logic [1:0]  lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Offending low address bits are dropped here; the caller decides whether to trap.
  assign lane  = (size[1:0] == 2'b00) ? off_lo :
                 (size[1:0] == 2'b01) ? {off_lo[1], 1'b0} : 2'b00;
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be         = '0;
    wdata_rep  = '0;
    rdata_ext  = '0;
    invalid    = 1'b0;
    misaligned = 1'b0;
    case (size)
      F3_B: begin
        be        = BE_W'(4'b0001 << lane);
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{rbyte[7]}}, rbyte};
      end
      F3_BU: begin
        invalid   = we;
        rdata_ext = {24'd0, rbyte};
      end
      F3_H: begin
        be         = BE_W'(4'b0011 << lane);
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{rhalf[15]}}, rhalf};
        misaligned = off_lo[0];
      end
      F3_HU: begin
        invalid    = we;
        rdata_ext  = {16'd0, rhalf};
        misaligned = off_lo[0];
      end
      F3_W: begin
        be         = '1;
        wdata_rep  = wdata;
        rdata_ext  = rword;
        misaligned = |off_lo;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ky32_dmem_resp.sv
// ============================================================================
// Module   : ky32_dmem_resp
// Purpose  : KY32 data-memory responder with programmable access latency.
//            Optional: KY32_DMEM_MISALIGN_TRAP_EN faults misaligned H/W accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ky32_dmem_resp
  import ky32_mem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic            acc_we;
  logic [31:0]     acc_addr, acc_wdata;
  logic [2:0]      acc_size;
  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            oor, acc_err, access, mem_we;
  logic [BE_W-1:0] be;
  logic [31:0]     wdata_rep, rdata_ext, acc_rdata;
  logic            invalid, misaligned;

  // With zero latency the access uses the live request in the accept cycle.
  always_comb begin
    if (LATENCY == 0 && state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_size  = req_size;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
    end
  end

  assign off = acc_addr - BASE;
  assign idx = off[AW+1:2];
  assign oor = (off[31:2] >= 30'(DEPTH));

  ky32_lsu_align u_align (
    .we         (acc_we),
    .size       (acc_size),
    .off_lo     (off[1:0]),
    .wdata      (acc_wdata),
    .rword      (mem_q[idx]),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .invalid    (invalid),
    .misaligned (misaligned)
  );

`ifdef KY32_DMEM_MISALIGN_TRAP_EN
  assign acc_err = invalid | oor | misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign acc_err = invalid | oor;
`endif

  assign acc_rdata = (acc_err || acc_we) ? 32'd0 : rdata_ext;
  assign mem_we    = access && acc_we && !acc_err && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    access    = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (access) begin
      rdata_d = acc_rdata;
      err_d   = acc_err;
    end
    if (rst) req_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < BE_W; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ky32_dmem_resp.sv
// ============================================================================
// Module   : tb_ky32_dmem_resp
// Purpose  : Scoreboard bench for ky32_dmem_resp at latencies 1, 0 and 15.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ky32_dmem_resp;

  localparam int NU = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    int          u;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clk, rst;
  logic        req_valid [NU];
  logic        req_ready [NU];
  logic        req_we    [NU];
  logic [31:0] req_addr  [NU];
  logic [31:0] req_wdata [NU];
  logic [2:0]  req_size  [NU];
  logic        rsp_valid [NU];
  logic        rsp_ready [NU];
  logic [31:0] rsp_rdata [NU];
  logic        rsp_err   [NU];

  exp_t sb_q[$];
  int   checks, errors;

  ky32_dmem_resp #(.DEPTH(1024), .LATENCY(1), .BASE(32'h0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_size(req_size[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  ky32_dmem_resp #(.DEPTH(64), .LATENCY(0), .BASE(32'h0)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_size(req_size[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  ky32_dmem_resp #(.DEPTH(16), .LATENCY(15), .BASE(32'h8000_0000)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_size(req_size[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  function automatic int lat_of(input int u);
    case (u)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  // One transaction: waits for ready, handshakes, returns response and accept-to-valid cycles.
  task automatic xact(input int u, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wdata; req_size[u] = size;
    req_valid[u] = 1'b1;
    rsp_ready[u] = 1'b0;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (req_ready[u] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout u%0d: got %b, required 1", u, req_ready[u]);
    end
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    lat = 1;
    while (rsp_valid[u] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (rsp_valid[u] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout u%0d: got %b, required 1", u, rsp_valid[u]);
    end
    rd = rsp_rdata[u];
    er = rsp_err[u];
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0; req_size[u] = '0; rsp_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (req_ready[u] !== 1'b0) begin errors++; $display("FAIL reset_req_ready u%0d: got %b, required 0", u, req_ready[u]); end
      checks++;
      if (rsp_valid[u] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid u%0d: got %b, required 0", u, rsp_valid[u]); end
      checks++;
      if (rsp_rdata[u] !== 32'd0 || rsp_err[u] !== 1'b0) begin
        errors++; $display("FAIL reset_rsp u%0d: got rdata %h err %b, required 0/0", u, rsp_rdata[u], rsp_err[u]);
      end
    end
    rst = 1'b0;
    #1;
    for (int u = 0; u < NU; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1) begin errors++; $display("FAIL idle_req_ready u%0d: got %b, required 1", u, req_ready[u]); end
    end
  endtask

  task automatic test_basic();
    vec_t v[$];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    v.push_back(vec_t'{0, 1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    v.push_back(vec_t'{0, 1'b1, 32'hFFC, 32'hA5A55A5A, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'hFFC, 32'h0,        3'b010, 32'hA5A55A5A, 1'b0});
    foreach (v[i]) begin
      sb_q.push_back(exp_t'{v[i].rdata, v[i].err, lat_of(v[i].u) + 1});
      xact(v[i].u, v[i].we, v[i].addr, v[i].wdata, v[i].size, rd, er, lat);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL basic[%0d] rdata: got %h, required %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL basic[%0d] err: got %b, required %b", i, er, e.err); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL basic[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_lanes();
    vec_t v[$];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    v.push_back(vec_t'{0, 1'b1, 32'h10, 32'h11223344, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b1, 32'h13, 32'h12345680, 3'b000, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h80223344, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF8022, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h12, 32'h0,        3'b101, 32'h00008022, 1'b0});
    v.push_back(vec_t'{0, 1'b1, 32'h10, 32'hAAAABEEF, 3'b001, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h10, 32'h0,        3'b010, 32'h8022BEEF, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h10, 32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h11, 32'h0,        3'b000, 32'hFFFFFFBE, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h12, 32'h0,        3'b100, 32'h00000022, 1'b0});
    foreach (v[i]) begin
      sb_q.push_back(exp_t'{v[i].rdata, v[i].err, lat_of(v[i].u) + 1});
      xact(v[i].u, v[i].we, v[i].addr, v[i].wdata, v[i].size, rd, er, lat);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL lanes[%0d] rdata: got %h, required %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL lanes[%0d] err: got %b, required %b", i, er, e.err); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL lanes[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_errors();
    vec_t v[$];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    v.push_back(vec_t'{0, 1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b1, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b1, 32'h10,   32'hFFFFFFFF, 3'b100, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b1, 32'h10,   32'hFFFFFFFF, 3'b110, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b0, 32'h10,   32'h0,        3'b010, 32'h8022BEEF, 1'b0});
`ifdef KY32_DMEM_MISALIGN_TRAP_EN
    v.push_back(vec_t'{0, 1'b0, 32'h12,   32'h0,        3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b0, 32'h11,   32'h0,        3'b001, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b1, 32'h11,   32'h01020304, 3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{0, 1'b0, 32'h10,   32'h0,        3'b010, 32'h8022BEEF, 1'b0});
`else
    v.push_back(vec_t'{0, 1'b0, 32'h12,   32'h0,        3'b010, 32'h8022BEEF, 1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h11,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    v.push_back(vec_t'{0, 1'b1, 32'h11,   32'h01020304, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{0, 1'b0, 32'h10,   32'h0,        3'b010, 32'h01020304, 1'b0});
`endif
    foreach (v[i]) begin
      sb_q.push_back(exp_t'{v[i].rdata, v[i].err, lat_of(v[i].u) + 1});
      xact(v[i].u, v[i].we, v[i].addr, v[i].wdata, v[i].size, rd, er, lat);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL errors[%0d] rdata: got %h, required %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL errors[%0d] err: got %b, required %b", i, er, e.err); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL errors[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_latency();
    vec_t v[$];
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    v.push_back(vec_t'{1, 1'b1, 32'h04,        32'h12345678, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{1, 1'b0, 32'h04,        32'h0,        3'b010, 32'h12345678, 1'b0});
    v.push_back(vec_t'{1, 1'b0, 32'h07,        32'h0,        3'b000, 32'h00000012, 1'b0});
    v.push_back(vec_t'{1, 1'b0, 32'h100,       32'h0,        3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{2, 1'b1, 32'h8000_0008, 32'hCAFEBABE, 3'b010, 32'h0,        1'b0});
    v.push_back(vec_t'{2, 1'b0, 32'h8000_0008, 32'h0,        3'b010, 32'hCAFEBABE, 1'b0});
    v.push_back(vec_t'{2, 1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'h0,        1'b1});
    v.push_back(vec_t'{2, 1'b0, 32'h8000_0040, 32'h0,        3'b010, 32'h0,        1'b1});
    foreach (v[i]) begin
      sb_q.push_back(exp_t'{v[i].rdata, v[i].err, lat_of(v[i].u) + 1});
      xact(v[i].u, v[i].we, v[i].addr, v[i].wdata, v[i].size, rd, er, lat);
      e = sb_q.pop_front();
      checks++;
      if (rd !== e.rdata) begin errors++; $display("FAIL latency[%0d] rdata: got %h, required %h", i, rd, e.rdata); end
      checks++;
      if (er !== e.err) begin errors++; $display("FAIL latency[%0d] err: got %b, required %b", i, er, e.err); end
      checks++;
      if (lat !== e.lat) begin errors++; $display("FAIL latency[%0d] cycles: got %0d, required %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    sb_q.push_back(exp_t'{32'hA5A55A5A, 1'b0, 2});
    sb_q.push_back(exp_t'{32'h000000A5, 1'b0, 2});
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_start_ready: got %b, required 1", req_ready[0]); end
    req_we[0] = 1'b0; req_addr[0] = 32'hFFC; req_size[0] = 3'b010; req_valid[0] = 1'b1;
    rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    // Second request presented immediately and held throughout the stall.
    req_addr[0] = 32'hFFF; req_size[0] = 3'b100;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    e = sb_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b, required 1", k, rsp_valid[0]); end
      checks++;
      if (rsp_rdata[0] !== e.rdata) begin errors++; $display("FAIL bp_rdata[%0d]: got %h, required %h", k, rsp_rdata[0], e.rdata); end
      checks++;
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b, required 0", k, req_ready[0]); end
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_err[0] !== e.err) begin errors++; $display("FAIL bp_err: got %b, required %b", rsp_err[0], e.err); end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_after_handshake: got valid %b ready %b, required 0/1", rsp_valid[0], req_ready[0]);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL bp_second_wait: got valid %b ready %b, required 0/0", rsp_valid[0], req_ready[0]);
    end
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    e = sb_q.pop_front();
    checks++;
    if (n !== e.lat) begin errors++; $display("FAIL bp_second_latency: got %0d, required %0d", n, e.lat); end
    checks++;
    if (rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err) begin
      errors++; $display("FAIL bp_second_rsp: got %h/%b, required %h/%b", rsp_rdata[0], rsp_err[0], e.rdata, e.err);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, rd, er, lat);
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL rmid_prefill err: got %b, required 0", er); end
    req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h5; req_size[0] = 3'b010;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_rsp_valid: got %b, required 0", rsp_valid[0]); end
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rmid_req_ready: got %b, required 1", req_ready[0]); end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rmid_no_late_rsp: got %b, required 0", rsp_valid[0]); end
    sb_q.push_back(exp_t'{32'hCAFEF00D, 1'b0, 2});
    xact(0, 1'b0, 32'h20, 32'h0, 3'b010, rd, er, lat);
    e = sb_q.pop_front();
    checks++;
    if (rd !== e.rdata) begin errors++; $display("FAIL rmid_readback rdata: got %h, required %h", rd, e.rdata); end
    checks++;
    if (er !== e.err) begin errors++; $display("FAIL rmid_readback err: got %b, required %b", er, e.err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_lanes();
    test_errors();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
